// File: rtl/div_unit.sv
// Signed restoring divider: WIDTH-cycle iterative quotient/remainder on operand
// magnitudes, followed by a one-cycle sign fix. Divide-by-zero short-circuits to DONE.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dmag;
  logic             qneg, rneg;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   diff;
  logic             last;

  // Remainder stays below the divisor magnitude, so the shifted value fits WIDTH
  // bits; the extra diff bit is only the borrow.
  assign rem_sh = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign diff   = {1'b0, rem_sh} - {1'b0, dmag};
  assign last   = (cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dmag <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      lo   <= '0;
      hi   <= '0;
      div0 <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt  <= '0;
          rem  <= '0;
          quo  <= dividend[WIDTH-1] ? -dividend : dividend;
          dmag <= divisor[WIDTH-1]  ? -divisor  : divisor;
          qneg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          rneg <= dividend[WIDTH-1];
          // Zero divisor: result is fixed, register it now for the DONE cycle.
          if (divisor == '0) begin
            lo   <= '1;
            hi   <= dividend;
            div0 <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (!diff[WIDTH]) begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          lo   <= qneg ? -quo : quo;
          hi   <= rneg ? -rem : rem;
          div0 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit (WIDTH=32): latency, signs,
// boundary cases, divide-by-zero, start masking, async clear and back-to-back.
module tb_div_unit;

  logic        clock, clear, start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div0;
  logic [31:0] lo, hi;

  int vec  = 0;
  int errs = 0;

  div_unit #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div0(div0), .lo(lo), .hi(hi)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Present a request at the falling edge, let one rising edge accept it.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Cycle index (1 = first cycle after accept) where done is seen, -1 on timeout.
  task automatic wait_done(output int done_cyc, output int busy_cnt);
    done_cyc = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    clear = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clock);
    vec++; if ({busy, done, div0} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b want 000", {busy, done, div0}); end
    vec++; if (lo !== 32'h0 || hi !== 32'h0) begin errs++; $display("FAIL reset_lohi got %h/%h want 0/0", lo, hi); end
    clear = 1'b1;
  endtask

  task automatic test_basic;
    int dc, bc;
    launch(32'd100, 32'd7);
    wait_done(dc, bc);
    vec++; if (dc !== 34) begin errs++; $display("FAIL basic_done_cycle got %0d want 34", dc); end
    vec++; if (bc !== 33) begin errs++; $display("FAIL basic_busy_cycles got %0d want 33", bc); end
    vec++; if (lo !== 32'd14 || hi !== 32'd2) begin errs++; $display("FAIL basic_result got %h/%h want e/2", lo, hi); end
    vec++; if (div0 !== 1'b0) begin errs++; $display("FAIL basic_div0 got %b want 0", div0); end
    @(negedge clock);
    vec++; if (lo !== 32'd14 || hi !== 32'd2 || done !== 1'b0) begin errs++; $display("FAIL basic_hold got %h/%h done=%b want e/2 done=0", lo, hi, done); end
  endtask

  task automatic test_signs;
    int dc, bc;
    launch(-32'sd100, 32'd7);
    wait_done(dc, bc);
    vec++; if (lo !== 32'hFFFF_FFF2 || hi !== 32'hFFFF_FFFE) begin errs++; $display("FAIL neg_dividend got %h/%h want fffffff2/fffffffe", lo, hi); end
    launch(32'd100, -32'sd7);
    wait_done(dc, bc);
    vec++; if (lo !== 32'hFFFF_FFF2 || hi !== 32'd2) begin errs++; $display("FAIL neg_divisor got %h/%h want fffffff2/2", lo, hi); end
    launch(-32'sd100, -32'sd7);
    wait_done(dc, bc);
    vec++; if (lo !== 32'd14 || hi !== 32'hFFFF_FFFE) begin errs++; $display("FAIL neg_both got %h/%h want e/fffffffe", lo, hi); end
  endtask

  task automatic test_boundary;
    int dc, bc;
    launch(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(dc, bc);
    vec++; if (lo !== 32'h8000_0000 || hi !== 32'h0 || div0 !== 1'b0) begin errs++; $display("FAIL minint_by_m1 got %h/%h div0=%b want 80000000/0 div0=0", lo, hi, div0); end
    launch(32'd5, 32'd9);
    wait_done(dc, bc);
    vec++; if (lo !== 32'h0 || hi !== 32'd5) begin errs++; $display("FAIL small_dividend got %h/%h want 0/5", lo, hi); end
    launch(-32'sd5, 32'd9);
    wait_done(dc, bc);
    vec++; if (lo !== 32'h0 || hi !== 32'hFFFF_FFFB) begin errs++; $display("FAIL small_neg_dividend got %h/%h want 0/fffffffb", lo, hi); end
    launch(32'd7, 32'h8000_0000);
    wait_done(dc, bc);
    vec++; if (lo !== 32'h0 || hi !== 32'd7) begin errs++; $display("FAIL minint_divisor got %h/%h want 0/7", lo, hi); end
  endtask

  task automatic test_div0;
    int dc, bc;
    launch(32'h1234_5678, 32'h0);
    wait_done(dc, bc);
    vec++; if (dc !== 1) begin errs++; $display("FAIL div0_done_cycle got %0d want 1", dc); end
    vec++; if (bc !== 0) begin errs++; $display("FAIL div0_busy got %0d want 0", bc); end
    vec++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h1234_5678 || div0 !== 1'b1) begin errs++; $display("FAIL div0_result got %h/%h div0=%b want ffffffff/12345678 div0=1", lo, hi, div0); end
    launch(-32'sd7, 32'd2);
    wait_done(dc, bc);
    vec++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || div0 !== 1'b0) begin errs++; $display("FAIL div0_cleared got %h/%h div0=%b want fffffffd/ffffffff div0=0", lo, hi, div0); end
  endtask

  task automatic test_ignore_start;
    int dc;
    dc = -1;
    launch(32'd100, 32'd7);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (i == 5)  begin start = 1'b1; dividend = 32'd50; divisor = 32'd5; end
      if (i == 10) start = 1'b0;
      if (done) begin dc = i; break; end
    end
    vec++; if (dc !== 34) begin errs++; $display("FAIL ignore_done_cycle got %0d want 34", dc); end
    vec++; if (lo !== 32'd14 || hi !== 32'd2) begin errs++; $display("FAIL ignore_result got %h/%h want e/2", lo, hi); end
    @(negedge clock);
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL ignore_no_relaunch got busy=%b want 0", busy); end
  endtask

  task automatic test_clear_midrun;
    int seen, dc, bc;
    seen = 0;
    launch(32'd100, 32'd7);
    repeat (10) @(negedge clock);
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL clear_pre_busy got %b want 1", busy); end
    clear = 1'b0;
    #1;
    vec++; if ({busy, done, div0} !== 3'b000 || lo !== 32'h0 || hi !== 32'h0) begin errs++; $display("FAIL clear_async got flags=%b lo=%h hi=%h want 000/0/0", {busy, done, div0}, lo, hi); end
    start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    repeat (2) @(negedge clock);
    vec++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL clear_start_masked got busy=%b done=%b want 0/0", busy, done); end
    start = 1'b0;
    clear = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done || busy) seen++;
    end
    vec++; if (seen !== 0) begin errs++; $display("FAIL clear_no_done got %0d active cycles want 0", seen); end
    launch(32'd6, 32'd3);
    wait_done(dc, bc);
    vec++; if (dc !== 34 || lo !== 32'd2 || hi !== 32'd0) begin errs++; $display("FAIL clear_recover got cyc=%0d %h/%h want 34 2/0", dc, lo, hi); end
  endtask

  task automatic test_back_to_back;
    int dc1, dc2;
    dc1 = -1; dc2 = -1;
    launch(32'd20, 32'd3);
    start = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clock);
      if (done && dc1 < 0) begin
        dc1 = i;
        vec++; if (lo !== 32'd6 || hi !== 32'd2) begin errs++; $display("FAIL b2b_first got %h/%h want 6/2", lo, hi); end
        dividend = 32'd21; divisor = 32'd4;
      end else if (done) begin
        dc2 = i;
        break;
      end
      if (i == 35) begin
        vec++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL b2b_idle got busy=%b done=%b want 0/0", busy, done); end
      end
      if (i == 36) begin
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_relaunch got busy=%b want 1", busy); end
        start = 1'b0;
      end
    end
    start = 1'b0;
    vec++; if (dc1 !== 34 || dc2 !== 69) begin errs++; $display("FAIL b2b_timing got %0d/%0d want 34/69", dc1, dc2); end
    vec++; if (lo !== 32'd5 || hi !== 32'd1) begin errs++; $display("FAIL b2b_second got %h/%h want 5/1", lo, hi); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signs;
    test_boundary;
    test_div0;
    test_ignore_start;
    test_clear_midrun;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 clock  input  1  the only clock; all state updates on the rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a divide; sampled on the rising edge.
REQ-005 dividend  input  WIDTH  signed two's-complement numerator.
REQ-006 divisor  input  WIDTH  signed two's-complement denominator.
REQ-007 busy  output  1  high while a divide is in progress.
REQ-008 done  output  1  one-cycle pulse marking a valid result.
REQ-009 div0  output  1  high when the divisor of the latest result was zero.
REQ-010 lo  output  WIDTH  signed quotient.
REQ-011 hi  output  WIDTH  signed remainder.

Function
REQ-012 The block SHALL implement states IDLE, RUN, FIX and DONE.
REQ-013 In IDLE with start=1 at an edge, the block SHALL latch both operands and clear the iteration counter.
- Magnitudes: two's-complement negation (invert, +1) of each negative operand, truncated to WIDTH.
- Sign flags: quotient sign = dividend sign XOR divisor sign; remainder sign = dividend sign.
- Next state: RUN.
REQ-014 start SHALL be ignored in RUN, FIX and DONE; operand changes after acceptance SHALL NOT affect the result.
REQ-015 RUN SHALL perform one restoring-division step per cycle for exactly WIDTH cycles:
- shift the {remainder, quotient} pair left by one;
- subtract the divisor magnitude from the remainder;
- if the difference is non-negative, keep it and set the quotient LSB to 1; otherwise restore the remainder and set the LSB to 0.
REQ-016 After the WIDTH-th RUN step, the block SHALL enter FIX and apply sign correction by two's-complement negation, modulo 2^WIDTH.
REQ-017 On leaving FIX, the block SHALL register lo and hi and enter DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 With WIDTH=32, done SHALL be high during the 34th cycle after the accepting edge.
- Latency: 32 RUN cycles + 1 FIX cycle + 1 DONE cycle.
REQ-020 busy SHALL be 1 in RUN and FIX, and 0 in IDLE and DONE.
REQ-021 Divisor zero at acceptance: the block SHALL skip RUN and FIX and go directly to DONE, with:
- lo = all ones;
- hi = dividend;
- div0 = 1;
- done high in the cycle immediately after the accepting edge.
REQ-022 div0 SHALL be 0 for every accepted divide with a non-zero divisor.
REQ-023 Most-negative dividend divided by -1: lo SHALL equal the most-negative value (wrap-around) and hi SHALL be 0; no flag is raised.
REQ-024 A dividend whose magnitude is below the divisor magnitude SHALL produce lo=0 and hi=dividend.
REQ-025 lo, hi and div0 SHALL hold their last values until the next result is registered.
REQ-026 start=1 held continuously SHALL launch a new divide from the IDLE cycle after DONE; back-to-back operation takes no extra idle cycle.

Reset
REQ-027 clear=0 SHALL, asynchronously and regardless of state (including mid-RUN), force:
- state = IDLE;
- busy = 0, done = 0, div0 = 0;
- lo = 0, hi = 0;
- iteration counter and internal registers = 0.
REQ-028 While clear=0, start SHALL be ignored.
REQ-029 After clear rises, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-030 dividend=100, divisor=7, start pulsed -> busy for 33 cycles; done in the 34th cycle; lo=14; hi=2; div0=0.
REQ-031 dividend=-100, divisor=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2).
- Also dividend=100, divisor=-7 -> lo=-14, hi=2.
REQ-032 dividend=0x80000000, divisor=0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
- Also dividend=5, divisor=9 -> lo=0, hi=5.
REQ-033 dividend=0x12345678, divisor=0 -> done in the next cycle, lo=0xFFFFFFFF, hi=0x12345678, div0=1, busy never high.
REQ-034 Start 100/7 and drive start=1 with new operands during RUN -> the new request is ignored and the result is 14/2.
- Assert clear=0 at RUN cycle 10 -> all outputs are 0 immediately and no done pulse follows.
- After release, 6/3 -> lo=2, hi=0.
